vga_timing_gen: RTL and testbench

//  Parametrised video timing generator and pixel source for the LCD/VGA path. Produces
//  HS/VS/BLANK/RGB for any panel geometry and sync polarity, with selectable built-in test

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_sync_counter.sv | 76 +++++++
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the video timing generator and its pattern sources.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRID  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_EXT   = 2'd2,
    MODE_SOLID = 2'd3
  } vid_mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_WHITE = rgb_t'(24'hFFFFFF);
  localparam rgb_t RGB_BLACK = rgb_t'(24'h000000);

  // Colour bars left to right.
  localparam rgb_t BAR_LUT [8] = '{
    rgb_t'(24'hFFFFFF), rgb_t'(24'hFFFF00), rgb_t'(24'h00FFFF), rgb_t'(24'h00FF00),
    rgb_t'(24'hFF00FF), rgb_t'(24'hFF0000), rgb_t'(24'h0000FF), rgb_t'(24'h000000)
  };

  function automatic int line_total(input int disp, input int fp, input int pulse, input int bp);
    return disp + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with region decode and active-area coordinates.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 12,
  parameter int VPULSE = 3,
  parameter int VBP    = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic                       active,
  output logic                       hs_on,
  output logic                       vs_on,
  output logic                       line_first,
  output logic                       frame_first,
  output logic [$clog2(HDISP)-1:0]   act_x,
  output logic [$clog2(VDISP)-1:0]   act_y
);

  localparam int HTOTAL = line_total(HDISP, HFP, HPULSE, HBP);
  localparam int VTOTAL = line_total(VDISP, VFP, VPULSE, VBP);
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);
  localparam int HSTART = HTOTAL - HDISP;
  localparam int VSTART = VTOTAL - VDISP;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_act, v_act;

  // Counters park at the origin while disabled so a re-enable starts a fresh frame.
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (enable) begin
      if (h_cnt_q == HW'(HTOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VW'(VTOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_act       = (h_cnt_q >= HW'(HSTART));
    v_act       = (v_cnt_q >= VW'(VSTART));
    active      = h_act && v_act;
    hs_on       = (h_cnt_q >= HW'(HFP)) && (h_cnt_q < HW'(HFP + HPULSE));
    vs_on       = (v_cnt_q >= VW'(VFP)) && (v_cnt_q < VW'(VFP + VPULSE));
    line_first  = (h_cnt_q == '0);
    frame_first = line_first && (v_cnt_q == '0);
    act_x       = h_act ? XW'(h_cnt_q - HW'(HSTART)) : '0;
    act_y       = v_act ? YW'(v_cnt_q - VW'(VSTART)) : '0;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: sync/blank outputs plus grid, bars, solid or FIFO-fed pixels.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          HFP       = 40,
  parameter int          HPULSE    = 48,
  parameter int          HBP       = 40,
  parameter int          VFP       = 12,
  parameter int          VPULSE    = 3,
  parameter int          VBP       = 40,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int          GRID_LOG2 = 4,
  parameter logic [23:0] UFLOW_RGB = 24'hFF00FF
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst_n,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [23:0]                solid_rgb,
  input  logic [23:0]                ext_rgb,
  input  logic                       ext_empty,
  output logic                       ext_rd,
  input  logic                       uflow_clr,
  output logic                       uflow,
  output logic                       vid_hs,
  output logic                       vid_vs,
  output logic                       vid_blank,
  output logic [23:0]                vid_rgb,
  output logic [$clog2(HDISP)-1:0]   pix_x,
  output logic [$clog2(VDISP)-1:0]   pix_y,
  output logic                       frame_start,
  output logic                       line_start
);

  localparam int XW    = $clog2(HDISP);
  localparam int YW    = $clog2(VDISP);
  localparam int BAR_W = HDISP / 8;

  logic          active, hs_on, vs_on, line_first, frame_first, act;
  logic [XW-1:0] act_x;
  logic [YW-1:0] act_y;

  vga_sync_counter #(
    .HDISP (HDISP), .VDISP (VDISP),
    .HFP   (HFP),   .HPULSE(HPULSE), .HBP(HBP),
    .VFP   (VFP),   .VPULSE(VPULSE), .VBP(VBP)
  ) u_sync (
    .clk        (pixel_clk),
    .rst_n      (pixel_rst_n),
    .enable     (enable),
    .active     (active),
    .hs_on      (hs_on),
    .vs_on      (vs_on),
    .line_first (line_first),
    .frame_first(frame_first),
    .act_x      (act_x),
    .act_y      (act_y)
  );

  vid_mode_e     mode_q, mode_d;
  logic [XW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic          uflow_q, uflow_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic          fs_q, fs_d, ls_q, ls_d;
  rgb_t          rgb_q, rgb_d, pattern;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;

  assign act    = enable && active;
  assign ext_rd = act && (mode_q == MODE_EXT) && !ext_empty;

  always_comb begin
    mode_d = mode_q;
    if (!enable) begin
      mode_d = MODE_GRID;
    end else if (frame_first) begin
      mode_d = vid_mode_e'(mode);
    end

    // Bar counter restarts every line; the last bar keeps counting to absorb the remainder.
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (act) begin
      if ((bar_cnt_q == XW'(BAR_W - 1)) && (bar_idx_q != 3'd7)) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
        bar_idx_d = bar_idx_q;
      end
    end

    pattern = RGB_BLACK;
    case (mode_q)
      MODE_GRID:  pattern = ((act_x[GRID_LOG2-1:0] == '0) || (act_y[GRID_LOG2-1:0] == '0))
                            ? RGB_WHITE : RGB_BLACK;
      MODE_BARS:  pattern = BAR_LUT[bar_idx_q];
      MODE_EXT:   pattern = ext_empty ? rgb_t'(UFLOW_RGB) : rgb_t'(ext_rgb);
      MODE_SOLID: pattern = rgb_t'(solid_rgb);
      default:    pattern = RGB_BLACK;
    endcase

    // A fresh underflow outranks a simultaneous clear.
    uflow_d = uflow_q;
    if (uflow_clr) begin
      uflow_d = 1'b0;
    end
    if (act && (mode_q == MODE_EXT) && ext_empty) begin
      uflow_d = 1'b1;
    end

    hs_d    = (enable && hs_on) ? HS_POL : !HS_POL;
    vs_d    = (enable && vs_on) ? VS_POL : !VS_POL;
    blank_d = act;
    fs_d    = enable && frame_first;
    ls_d    = enable && line_first;
    rgb_d   = act ? pattern : RGB_BLACK;
    pix_x_d = act ? act_x : '0;
    pix_y_d = act ? act_y : '0;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      mode_q    <= MODE_GRID;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      uflow_q   <= 1'b0;
      hs_q      <= !HS_POL;
      vs_q      <= !VS_POL;
      blank_q   <= 1'b0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
      rgb_q     <= RGB_BLACK;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      uflow_q   <= uflow_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_q   <= blank_d;
      fs_q      <= fs_d;
      ls_q      <= ls_d;
      rgb_q     <= rgb_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
    end
  end

  assign uflow       = uflow_q;
  assign vid_hs      = hs_q;
  assign vid_vs      = vs_q;
  assign vid_blank   = blank_q;
  assign vid_rgb     = rgb_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 16x8 panel with 2-pixel/2-line porches, active-high syncs.
module tb_vga_timing_gen;

  localparam int HD  = 16;
  localparam int VD  = 8;
  localparam int HT  = 22;
  localparam int VT  = 14;
  localparam int HST = 6;
  localparam int VST = 6;
  localparam logic [23:0] SOLID = 24'h3C81E7;

  logic        clk = 1'b0;
  logic        rst_n, enable, ext_empty, uflow_clr;
  logic [1:0]  mode;
  logic [23:0] solid_rgb, ext_rgb, vid_rgb;
  logic        ext_rd, uflow, vid_hs, vid_vs, vid_blank, frame_start, line_start;
  logic [3:0]  pix_x;
  logic [2:0]  pix_y;

  int unsigned pop_cnt = 0;
  int          errors  = 0;
  int          checks  = 0;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
  } px_t;
  px_t exp_q[$];

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head word encodes how many words were popped before it.
  assign ext_rgb = {8'h5A, pop_cnt[15:0]};
  always @(posedge clk) if (ext_rd) pop_cnt <= pop_cnt + 1;

  vga_timing_gen #(
    .HDISP(HD), .VDISP(VD), .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(2), .VPULSE(2), .VBP(2), .HS_POL(1'b1), .VS_POL(1'b1),
    .GRID_LOG2(2), .UFLOW_RGB(24'hFF00FF)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(enable), .mode(mode),
    .solid_rgb(solid_rgb), .ext_rgb(ext_rgb), .ext_empty(ext_empty), .ext_rd(ext_rd),
    .uflow_clr(uflow_clr), .uflow(uflow), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_blank(vid_blank), .vid_rgb(vid_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_start(line_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] bar_col(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic push_frame(input int m);
    int          u    = 0;
    int unsigned base = pop_cnt;
    logic [23:0] c;
    for (int y = 0; y < VD; y++) begin
      for (int x = 0; x < HD; x++) begin
        case (m)
          0: c = ((x % 4 == 0) || (y % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
          1: c = bar_col(x / 2);
          2: begin
            if (y == 0 && x >= 10 && x <= 12) begin
              c = 24'hFF00FF;
              u++;
            end else begin
              c = {8'h5A, 16'(base + 32'(y * HD + x - u))};
            end
          end
          default: c = SOLID;
        endcase
        exp_q.push_back('{x, y, c});
      end
    end
  endtask

  // Called one cycle into a frame; steps raster state s, one state per clock.
  task automatic do_frame(input int m, input int next_m, input bit holes,
                          input bit clr_chk, input int abort_s);
    push_frame(m);
    for (int s = 1; s < HT * VT; s++) begin
      if (s == abort_s) return;
      if (s == 150) mode = next_m[1:0];
      ext_empty = holes && s >= 148 && s <= 150;
      uflow_clr = (holes && s >= 148 && s <= 150) || (clr_chk && s == 1);
      if (clr_chk && s == 2) chk("uflow_cleared", 32'(uflow), 32'(0));
      @(posedge clk); #1;
    end
    ext_empty = 1'b0;
    uflow_clr = 1'b0;
    @(posedge clk); #1;
    chk("frame_start_period", 32'(frame_start), 32'(1));
  endtask

  // Monitor: pops one expected pixel per active output and audits each frame's timing.
  initial begin
    bit  have_start = 1'b0;
    int  hpos = 0, vpos = 0, cyc = 0, hs_n = 0, vs_n = 0, bl_n = 0, ls_n = 0, pos_err = 0;
    px_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !enable) begin
        have_start = 1'b0;
      end else begin
        if (frame_start) begin
          if (have_start) begin
            chk("frame_cycles", 32'(cyc), 32'(HT * VT));
            chk("hs_cycles", 32'(hs_n), 32'(2 * VT));
            chk("vs_cycles", 32'(vs_n), 32'(2 * HT));
            chk("blank_cycles", 32'(bl_n), 32'(HD * VD));
            chk("line_starts", 32'(ls_n), 32'(VT));
            chk("timing_placement_errs", 32'(pos_err), 32'(0));
          end
          have_start = 1'b1;
          hpos = 0; vpos = 0; cyc = 0; hs_n = 0; vs_n = 0; bl_n = 0; ls_n = 0; pos_err = 0;
        end else if (have_start) begin
          hpos++;
          if (hpos == HT) begin
            hpos = 0;
            vpos = (vpos == VT - 1) ? 0 : vpos + 1;
          end
        end
        if (have_start) begin
          cyc++;
          hs_n += int'(vid_hs);
          vs_n += int'(vid_vs);
          bl_n += int'(vid_blank);
          ls_n += int'(line_start);
          if (vid_hs !== (hpos >= 2 && hpos < 4)) pos_err++;
          if (vid_vs !== (vpos >= 2 && vpos < 4)) pos_err++;
          if (vid_blank !== (hpos >= HST && vpos >= VST)) pos_err++;
          if (line_start !== (hpos == 0)) pos_err++;
          if (!vid_blank && vid_rgb !== 24'h0) pos_err++;
        end
        if (vid_blank) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_unexpected: got x=%0d y=%0d rgb=%06h expected no pixel",
                     pix_x, pix_y, vid_rgb);
          end else begin
            e = exp_q.pop_front();
            chk("pixel {y,x,rgb}", {1'b0, pix_y, pix_x, vid_rgb},
                {1'b0, 3'(e.y), 4'(e.x), e.rgb});
          end
        end
      end
    end
  end

  initial begin
    int unsigned pb;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; solid_rgb = SOLID;
    ext_empty = 1'b0; uflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hs", 32'(vid_hs), 32'(0));
    chk("reset_vs", 32'(vid_vs), 32'(0));
    chk("reset_blank_pulses", {29'd0, vid_blank, frame_start, line_start}, 32'(0));
    chk("reset_rgb", 32'(vid_rgb), 32'(0));
    chk("reset_pix", {25'd0, pix_y, pix_x}, 32'(0));
    chk("reset_rd_uflow", {30'd0, ext_rd, uflow}, 32'(0));

    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("disabled_idle", {28'd0, vid_blank, frame_start, line_start, vid_hs}, 32'(0));

    enable = 1'b1;
    @(posedge clk); #1;
    chk("first_frame_start", 32'(frame_start), 32'(1));
    chk("first_line_start", 32'(line_start), 32'(1));

    do_frame(0, 3, 1'b0, 1'b0, 0);   // grid; switch to solid mid-frame
    do_frame(3, 1, 1'b0, 1'b0, 0);   // solid
    do_frame(1, 2, 1'b0, 1'b0, 0);   // bars
    do_frame(2, 0, 1'b1, 1'b0, 0);   // FIFO with three empty pixels
    chk("uflow_sticky", 32'(uflow), 32'(1));
    chk("fifo_pops", pop_cnt, 32'(HD * VD - 3));

    pb = pop_cnt;
    do_frame(0, 0, 1'b0, 1'b1, 210); // grid, stops mid-line at x=5,y=3
    chk("no_pops_outside_fifo", pop_cnt, pb);
    chk("pre_reset_active", {28'd0, vid_blank, pix_y}, {28'd0, 1'b1, 3'd3});

    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_blank", {28'd0, vid_blank, pix_y}, 32'(0));
    chk("async_reset_pix_x", 32'(pix_x), 32'(0));
    chk("async_reset_hs_vs", {30'd0, vid_hs, vid_vs}, 32'(0));
    exp_q.delete();
    @(posedge clk); #1;
    chk("in_reset_no_start", 32'(frame_start), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_frame_start", 32'(frame_start), 32'(1));
    do_frame(0, 1, 1'b0, 1'b0, 210);

    enable = 1'b0;
    @(posedge clk); #1;
    chk("disable_blank", {29'd0, vid_blank, frame_start, vid_hs}, 32'(0));
    chk("disable_rgb", 32'(vid_rgb), 32'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("disabled_hold", 32'(vid_blank), 32'(0));
    enable = 1'b1;
    @(posedge clk); #1;
    chk("reenable_frame_start", 32'(frame_start), 32'(1));
    do_frame(1, 1, 1'b0, 1'b0, 0);   // bars after re-enable

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
